// File: rtl/fir_chk_pkg.sv
// Shared widths, FSM state type and saturating helper for the FIR output checker.
package fir_chk_pkg;

    localparam int NTAPS  = 9;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = 20;
    localparam int CNT_W  = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [PROD_W-1:0] prod_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fir_out_checker_if.sv
// Stimulus, DUT-output and status signals seen by the FIR output checker.
interface fir_out_checker_if;
    import fir_chk_pkg::*;

    sample_t          DIN;
    logic             VIN;
    coef_t            b0, b1, b2, b3, b4, b5, b6, b7, b8;
    sample_t          DOUT;
    logic             VOUT;
    logic             END_SIM;
    logic             MISMATCH;
    logic [CNT_W-1:0] ERR_CNT;
    logic [CNT_W-1:0] OUT_CNT;
    logic             OVERFLOW;
    logic             UNDERFLOW;
    logic             TIMED_OUT;

    modport master (
        output DIN, VIN, b0, b1, b2, b3, b4, b5, b6, b7, b8, DOUT, VOUT,
        input  END_SIM, MISMATCH, ERR_CNT, OUT_CNT, OVERFLOW, UNDERFLOW, TIMED_OUT
    );

    modport slave (
        input  DIN, VIN, b0, b1, b2, b3, b4, b5, b6, b7, b8, DOUT, VOUT,
        output END_SIM, MISMATCH, ERR_CNT, OUT_CNT, OVERFLOW, UNDERFLOW, TIMED_OUT
    );

endinterface

// File: rtl/fir_chk_fifo.sv
// Expected-sample queue: synchronous FIFO; a push while full is accepted only
// when a pop happens at the same edge.
module fir_chk_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit tells a full queue from an empty one.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fir_out_checker.sv
// Self-checking receiver: 9-tap FIR reference model, expected-sample queue,
// compare/timeout FSM. Define FIR_CHK_TOL_EN to accept |DOUT - exp| <= 1.
module fir_out_checker
    import fir_chk_pkg::*;
#(
    parameter int N_OUT      = 256,
    parameter int FIFO_DEPTH = 8,
    parameter int SHIFT      = 7,
    parameter int TIMEOUT    = 64
) (
    input  logic              CLK,
    input  logic              RST_n,
    fir_out_checker_if.slave  chk
);

    state_t           state;
    sample_t          hist [NTAPS-1];
    sample_t          taps [NTAPS];
    coef_t            coef [NTAPS];
    prod_t            prod [NTAPS];
    logic signed [ACC_W-1:0] acc;
    sample_t          exp_sample;
    sample_t          head;
    logic             full, empty;
    logic             active, push_req, push, pop;
    logic             overflow_evt, underflow_evt, mismatch_evt, err_evt;
    logic             cmp_fail, last_cmp, timer_hit;
    logic [CNT_W-1:0] timer, err_cnt, out_cnt;
    logic             mismatch, overflow, underflow, timed_out, end_sim;

    assign coef = '{chk.b0, chk.b1, chk.b2, chk.b3, chk.b4, chk.b5, chk.b6, chk.b7, chk.b8};

    // NOTE: every always_comb output gets a value before any conditional use,
    // so no latch is inferred; blocking assignments build the running sum.
    always_comb begin
        taps[0] = chk.DIN;
        for (int k = 1; k < NTAPS; k++) taps[k] = hist[k-1];
        acc = '0;
        for (int k = 0; k < NTAPS; k++) begin
            prod[k] = PROD_W'(coef[k]) * PROD_W'(taps[k]);
            acc     = acc + ACC_W'(prod[k]);
        end
    end

    assign exp_sample = DATA_W'(acc >>> SHIFT);

    assign active        = (state != DONE);
    assign pop           = active & chk.VOUT & ~empty;
    assign push_req      = active & chk.VIN;
    assign push          = push_req & (~full | pop);
    assign overflow_evt  = push_req & full & ~pop;
    assign underflow_evt = active & chk.VOUT & empty;

`ifdef FIR_CHK_TOL_EN
    logic signed [DATA_W:0] diff;
    assign diff     = (DATA_W+1)'(chk.DOUT) - (DATA_W+1)'(head);
    assign cmp_fail = (diff > 9'sd1) || (diff < -9'sd1);
`else
    assign cmp_fail = (chk.DOUT != head);
`endif

    assign mismatch_evt = pop & cmp_fail;
    assign err_evt      = mismatch_evt | underflow_evt | overflow_evt;
    assign last_cmp     = pop && (out_cnt == CNT_W'(N_OUT - 1));
    assign timer_hit    = (state == RUN) && !empty && !chk.VOUT
                          && (timer == CNT_W'(TIMEOUT - 1));

    fir_chk_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_n),
        .push  (push),
        .pop   (pop),
        .din   (exp_sample),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= IDLE;
            timer     <= '0;
            err_cnt   <= '0;
            out_cnt   <= '0;
            mismatch  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            timed_out <= 1'b0;
            end_sim   <= 1'b0;
            for (int k = 0; k < NTAPS - 1; k++) hist[k] <= '0;
        end else begin
            mismatch <= mismatch_evt;
            // The model advances even when the queue drops the sample.
            if (push_req) begin
                for (int k = 0; k < NTAPS - 1; k++) hist[k] <= taps[k];
            end
            if (err_evt)       err_cnt   <= sat_inc(err_cnt);
            if (pop)           out_cnt   <= out_cnt + 1'b1;
            if (overflow_evt)  overflow  <= 1'b1;
            if (underflow_evt) underflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (push) state <= RUN;
                end
                RUN: begin
                    if (!empty && !chk.VOUT) timer <= timer + 1'b1;
                    else                     timer <= '0;
                    if (last_cmp) begin
                        state   <= DONE;
                        end_sim <= 1'b1;
                    end else if (timer_hit) begin
                        state     <= DONE;
                        end_sim   <= 1'b1;
                        timed_out <= 1'b1;
                    end
                end
                DONE: ;
                default: state <= IDLE;
            endcase
        end
    end

    assign chk.END_SIM   = end_sim;
    assign chk.MISMATCH  = mismatch;
    assign chk.ERR_CNT   = err_cnt;
    assign chk.OUT_CNT   = out_cnt;
    assign chk.OVERFLOW  = overflow;
    assign chk.UNDERFLOW = underflow;
    assign chk.TIMED_OUT = timed_out;

endmodule

// File: tb/tb_fir_out_checker.sv
// Bench for fir_out_checker: a default-parameter instance tracked by a queue
// model and a small instance (N_OUT=4, TIMEOUT=16) for the end conditions.
module tb_fir_out_checker;
    import fir_chk_pkg::*;

    localparam int DEPTH     = 8;
    localparam int SHIFT_V   = 7;
    localparam int N_OUT_A   = 256;
    localparam int TIMEOUT_A = 64;
`ifdef FIR_CHK_TOL_EN
    localparam bit TOL = 1'b1;
`else
    localparam bit TOL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic signed [7:0] din = '0;
    logic signed [7:0] dout = '0;
    logic              vin = 1'b0;
    logic              vout = 1'b0;
    logic signed [7:0] coef [9];

    fir_out_checker_if bus_a ();
    fir_out_checker_if bus_s ();

    assign bus_a.DIN = din;  assign bus_a.VIN = vin;  assign bus_a.DOUT = dout;  assign bus_a.VOUT = vout;
    assign bus_a.b0 = coef[0]; assign bus_a.b1 = coef[1]; assign bus_a.b2 = coef[2];
    assign bus_a.b3 = coef[3]; assign bus_a.b4 = coef[4]; assign bus_a.b5 = coef[5];
    assign bus_a.b6 = coef[6]; assign bus_a.b7 = coef[7]; assign bus_a.b8 = coef[8];
    assign bus_s.DIN = din;  assign bus_s.VIN = vin;  assign bus_s.DOUT = dout;  assign bus_s.VOUT = vout;
    assign bus_s.b0 = coef[0]; assign bus_s.b1 = coef[1]; assign bus_s.b2 = coef[2];
    assign bus_s.b3 = coef[3]; assign bus_s.b4 = coef[4]; assign bus_s.b5 = coef[5];
    assign bus_s.b6 = coef[6]; assign bus_s.b7 = coef[7]; assign bus_s.b8 = coef[8];

    fir_out_checker #(.N_OUT(N_OUT_A), .FIFO_DEPTH(DEPTH), .SHIFT(SHIFT_V), .TIMEOUT(TIMEOUT_A))
        dut_a (.CLK(clk), .RST_n(rst_n), .chk(bus_a));
    fir_out_checker #(.N_OUT(4), .FIFO_DEPTH(DEPTH), .SHIFT(SHIFT_V), .TIMEOUT(16))
        dut_s (.CLK(clk), .RST_n(rst_n), .chk(bus_s));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Status snapshot: {END_SIM, MISMATCH, OVERFLOW, UNDERFLOW, TIMED_OUT, ERR_CNT, OUT_CNT}
    function automatic logic [36:0] snap_a();
        return {bus_a.END_SIM, bus_a.MISMATCH, bus_a.OVERFLOW, bus_a.UNDERFLOW,
                bus_a.TIMED_OUT, bus_a.ERR_CNT, bus_a.OUT_CNT};
    endfunction

    function automatic logic [36:0] snap_s();
        return {bus_s.END_SIM, bus_s.MISMATCH, bus_s.OVERFLOW, bus_s.UNDERFLOW,
                bus_s.TIMED_OUT, bus_s.ERR_CNT, bus_s.OUT_CNT};
    endfunction

    // Reference model for dut_a, tracked with plain integers and a queue.
    int m_x [9];
    int m_q [$];
    int m_err, m_out, m_timer;
    bit m_mis, m_ovf, m_udf, m_to, m_done, m_run;

    function automatic logic [36:0] model_vec();
        return {m_done, m_mis, m_ovf, m_udf, m_to, 16'(m_err), 16'(m_out)};
    endfunction

    task automatic model_reset();
        foreach (m_x[k]) m_x[k] = 0;
        m_q.delete();
        m_err = 0; m_out = 0; m_timer = 0;
        m_mis = 0; m_ovf = 0; m_udf = 0; m_to = 0; m_done = 0; m_run = 0;
    endtask

    function automatic int fir_expect();
        int acc = 0;
        int w;
        for (int k = 0; k < 9; k++) acc += int'(coef[k]) * m_x[k];
        w = (acc >>> SHIFT_V) & 255;
        return (w > 127) ? w - 256 : w;
    endfunction

    function automatic bit same(input int got, input int want);
        if (TOL) return (got - want <= 1) && (got - want >= -1);
        return got == want;
    endfunction

    task automatic err_inc();
        if (m_err < 65535) m_err++;
    endtask

    task automatic model_edge(input bit v_in, input int d_in, input bit v_out, input int d_out);
        bit had_data;
        int e;
        m_mis = 0;
        if (m_done) return;
        had_data = (m_q.size() > 0);
        if (v_out) begin
            if (!had_data) begin
                m_udf = 1; err_inc();
            end else begin
                e = m_q.pop_front();
                m_out++;
                if (!same(d_out, e)) begin m_mis = 1; err_inc(); end
            end
        end
        if (m_run && had_data && !v_out) m_timer++;
        else m_timer = 0;
        if (v_in) begin
            for (int k = 8; k > 0; k--) m_x[k] = m_x[k-1];
            m_x[0] = d_in;
            if (m_q.size() < DEPTH) begin
                m_q.push_back(fir_expect());
                m_run = 1;
            end else begin
                m_ovf = 1; err_inc();
            end
        end
        if (m_out == N_OUT_A) m_done = 1;
        else if (m_timer == TIMEOUT_A) begin m_done = 1; m_to = 1; end
    endtask

    task automatic cyc(input bit v_in, input int d_in, input bit v_out, input int d_out);
        @(negedge clk);
        vin = v_in; din = 8'(d_in); vout = v_out; dout = 8'(d_out);
        @(posedge clk);
        model_edge(v_in, int'(din), v_out, int'(dout));
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        vin = 1'b0; vout = 1'b0; rst_n = 1'b0;
        #1;
        model_reset();
        check("reset_a", 64'(snap_a()), 64'(37'd0));
        check("reset_s", 64'(snap_s()), 64'(37'd0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_basic_coef();
        foreach (coef[k]) coef[k] = '0;
        coef[0] = 8'sh40;
    endtask

    typedef struct {
        logic signed [7:0] b0;
        logic signed [7:0] din;
        logic signed [7:0] dout;
        int                exp_err;
    } vec_t;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin : main
        vec_t vecs [8];
        int   first_to;
        int   drain [8];

        vecs[0] = '{8'h40, 8'h20, 8'h10, 0};
        vecs[1] = '{8'h40, 8'h20, 8'h11, TOL ? 0 : 1};
        vecs[2] = '{8'h40, 8'h20, 8'h12, 1};
        vecs[3] = '{8'h40, 8'h20, 8'h0F, TOL ? 0 : 1};
        vecs[4] = '{8'h40, 8'hE0, 8'hF0, 0};
        vecs[5] = '{8'h7F, 8'h7F, 8'h7E, 0};
        vecs[6] = '{8'h80, 8'h80, 8'h80, 0};
        vecs[7] = '{8'h80, 8'h7F, 8'h81, 0};
        drain = '{1, 2, 3, 4, 5, 6, 7, 16};

        foreach (coef[k]) coef[k] = '0;
        repeat (2) @(posedge clk);
        do_reset();

        // Single-tap vectors: one push, compare two edges later.
        for (int i = 0; i < 8; i++) begin
            foreach (coef[k]) coef[k] = '0;
            coef[0] = vecs[i].b0;
            do_reset();
            cyc(1, int'(vecs[i].din), 0, 0);
            cyc(0, 0, 0, 0);
            check("vec_mis_low", 64'(bus_a.MISMATCH), 64'(0));
            cyc(0, 0, 1, int'(vecs[i].dout));
            check("vec_mis_pulse", 64'(bus_a.MISMATCH), 64'(vecs[i].exp_err != 0));
            cyc(0, 0, 0, 0);
            check("vec_err", 64'(bus_a.ERR_CNT), 64'(vecs[i].exp_err));
            check("vec_out", 64'(bus_a.OUT_CNT), 64'(1));
            check("vec_model", 64'(snap_a()), 64'(model_vec()));
        end

        // Impulse through bk = 2*(k+1), FIR latency of three edges.
        for (int k = 0; k < 9; k++) coef[k] = 8'(2 * (k + 1));
        do_reset();
        for (int c = 0; c < 12; c++) begin
            cyc(c < 9, (c == 0) ? 64 : 0, c >= 3, (c >= 3) ? c - 2 : 0);
            check("impulse_cyc", 64'(snap_a()), 64'(model_vec()));
        end
        check("impulse_err", 64'(bus_a.ERR_CNT), 64'(0));
        check("impulse_out", 64'(bus_a.OUT_CNT), 64'(9));

        // Underflow right after reset, then a push at the same edge as VOUT.
        set_basic_coef();
        do_reset();
        cyc(0, 0, 1, 0);
        check("udf_first", 64'({bus_a.UNDERFLOW, bus_a.ERR_CNT, bus_a.OUT_CNT}), 64'({1'b1, 16'd1, 16'd0}));
        cyc(1, 32, 1, 16);
        check("udf_same_edge", 64'({bus_a.UNDERFLOW, bus_a.ERR_CNT, bus_a.OUT_CNT}), 64'({1'b1, 16'd2, 16'd0}));
        cyc(0, 0, 1, 16);
        check("udf_then_pop", 64'({bus_a.MISMATCH, bus_a.ERR_CNT, bus_a.OUT_CNT}), 64'({1'b0, 16'd2, 16'd1}));

        // Overflow: nine pushes into a depth-8 queue, then push+pop while full.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cyc(1, 2 * i, 0, 0);
            if (i == 7) check("ovf_before", 64'({bus_a.OVERFLOW, bus_a.ERR_CNT}), 64'({1'b0, 16'd0}));
        end
        check("ovf_set", 64'({bus_a.OVERFLOW, bus_a.ERR_CNT}), 64'({1'b1, 16'd1}));
        cyc(1, 32, 1, 0);
        check("ovf_full_pushpop", 64'({bus_a.OVERFLOW, bus_a.ERR_CNT, bus_a.OUT_CNT}), 64'({1'b1, 16'd1, 16'd1}));
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, drain[i]);
        check("ovf_drain", 64'({bus_a.UNDERFLOW, bus_a.ERR_CNT, bus_a.OUT_CNT}), 64'({1'b0, 16'd1, 16'd9}));

        // N_OUT=4 end condition on the small instance, then frozen afterwards.
        do_reset();
        cyc(1, 32, 0, 0);
        cyc(1, 64, 0, 0);
        cyc(1, 96, 1, 16);
        cyc(1, -32, 1, 32);
        cyc(0, 0, 1, 48);
        check("end_before", 64'({bus_s.END_SIM, bus_s.OUT_CNT}), 64'({1'b0, 16'd3}));
        cyc(0, 0, 1, -16);
        check("end_after", 64'(snap_s()), 64'({5'b10000, 16'd0, 16'd4}));
        cyc(0, 0, 1, 0);
        cyc(1, 32, 0, 0);
        check("end_frozen", 64'(snap_s()), 64'({5'b10000, 16'd0, 16'd4}));
        check("end_model_a", 64'(snap_a()), 64'(model_vec()));

        // TIMEOUT=16 on the small instance: three pushes and no VOUT.
        do_reset();
        first_to = -1;
        for (int c = 0; c < 40; c++) begin
            cyc(c < 3, 32, 0, 0);
            if (first_to < 0 && bus_s.TIMED_OUT) first_to = c;
        end
        check("timeout_cycle", 64'(first_to), 64'(16));
        check("timeout_flags", 64'(snap_s()), 64'({5'b10001, 16'd0, 16'd0}));
        check("timeout_model_a", 64'(snap_a()), 64'(model_vec()));

        // Reset mid-run clears the queue: stale heads must not reach the next run.
        do_reset();
        repeat (3) cyc(1, 32, 0, 0);
        cyc(0, 0, 1, 85);
        check("midrun_err", 64'(bus_a.ERR_CNT), 64'(1));
        do_reset();
        cyc(1, 64, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32);
        cyc(0, 0, 0, 0);
        check("midrun_fresh", 64'(snap_a()), 64'({5'b00000, 16'd0, 16'd1}));

        // Randomized traffic against the model.
        for (int r = 0; r < 3; r++) begin
            foreach (coef[k]) coef[k] = 8'($urandom);
            do_reset();
            for (int c = 0; c < 200; c++) begin
                bit v_o;
                int d_o;
                if (m_q.size() > 0) begin
                    v_o = ($urandom_range(0, 3) != 0);
                    d_o = m_q[0];
                    if ($urandom_range(0, 7) == 0) d_o = d_o + int'($urandom_range(0, 4)) - 2;
                end else begin
                    v_o = ($urandom_range(0, 9) == 0);
                    d_o = int'($urandom_range(0, 255)) - 128;
                end
                cyc($urandom_range(0, 1) == 1, int'($urandom_range(0, 255)) - 128, v_o, d_o);
                check("rand_cyc", 64'(snap_a()), 64'(model_vec()));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
